hc595_chain_driver: RTL
=======================

Name: hc595_chain_driver

Overview:
- Parametrised serial driver for daisy-chained 74HC595-style shift registers: OLED/LED segment panels and GPIO expanders on the SoC peripheral bus.
- Accepts a DATA_WIDTH-bit word with a one-cycle strobe and shifts it out on DS/SH_CP with a configurable bit rate and bit order.
- Pulses ST_CP once at the end of each frame so the outputs update.
- Reports Busy/Done and holds one frame in a buffer, so software can queue the next frame back-to-back.

Parameters:
- DATA_WIDTH, 16: total bits per frame (8 × number of chained devices); must be 2..256.
- DIV_MAX, 4: each SH_CP half-period and the ST_CP pulse last DIV_MAX+1 Clk cycles; must be ≥1.
- LSB_FIRST, 0: 0 shifts bit DATA_WIDTH-1 first; 1 shifts bit 0 first.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Data  in  DATA_WIDTH  frame to send; sampled when S_EN=1.
- S_EN  in  1  one-cycle send strobe.
- Busy  out  1  high while a frame is shifting or latching.
- Done  out  1  one-cycle pulse when a frame's ST_CP pulse completes.
- Pend  out  1  high while a buffered frame is waiting.
- SH_CP  out  1  shift clock; the device samples DS on its rising edge.
- ST_CP  out  1  storage latch clock.
- DS  out  1  serial data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - SH_CP=0, ST_CP=0, DS=0, Busy=0, Done=0, Pend=0.
  - Divider and bit counter cleared; shift and pending registers cleared.
  - No latch pulse is produced for an aborted frame.
- All outputs are registered.
- Divider:
  - Counts 0..DIV_MAX only while state≠IDLE; it is cleared on frame start.
  - tick = (div==DIV_MAX).
- FSM states: IDLE, SH_LO, SH_HI, LATCH.
- IDLE with S_EN=1 at edge t0:
  - Load shift register from Data; go to SH_LO; Busy=1.
  - SH_CP=0; DS = first bit (Data[DATA_WIDTH-1], or Data[0] if LSB_FIRST).
- SH_LO, on tick: go to SH_HI; SH_CP=1; DS held.
- SH_HI, on tick:
  - If bitcnt==DATA_WIDTH-1: go to LATCH; SH_CP=0; ST_CP=1; DS held.
  - Otherwise: bitcnt+1; go to SH_LO; SH_CP=0; DS = next bit.
- LATCH, on tick:
  - ST_CP=0; Done=1 for one cycle.
  - If Pend or S_EN is high on this edge: start the next frame immediately, exactly as from IDLE. The data source is the S_EN word if S_EN=1, else the pending word. Pend is cleared and Busy stays 1.
  - Otherwise go to IDLE with Busy=0.
- S_EN while Busy:
  - Data is stored in the pending register and Pend=1.
  - A further S_EN overwrites it (latest wins); frames are never corrupted mid-shift.
- Latency:
  - Done is high during the cycle after edge t0 + (2·DATA_WIDTH+1)·(DIV_MAX+1).
  - For defaults: t0+165.
- Data must not change the in-flight frame; only the shift register drives DS.

Optional Feature:
- Macro: HC595_AUTO_REFRESH_EN.
- When defined:
  - In IDLE, after REFRESH_GAP = 64·(DIV_MAX+1) idle cycles, the last transmitted frame is re-sent automatically, with an identical waveform.
  - Done is not pulsed for refresh frames.
  - Busy is asserted during refresh frames.
  - An S_EN during a refresh frame is buffered as pending.
  - No refresh occurs before the first S_EN after reset.
- When undefined: the block is strictly one-shot and stays in IDLE indefinitely.

Decomposition:
- Package hc595_pkg holds:
  - the state enum (IDLE, SH_LO, SH_HI, LATCH);
  - the refresh-gap multiplier constant (64);
  - a function computing bitcnt width, $clog2(DATA_WIDTH).
- One sub-module, hc595_clk_div: divider with enable and synchronous clear, producing the tick output.

Test Plan:
1. DATA_WIDTH=16, DIV_MAX=4, LSB_FIRST=0, S_EN with Data=16'hA5C3:
   - DS sampled on 16 SH_CP rising edges = 1010_0101_1100_0011.
   - Exactly one ST_CP pulse of 5 cycles.
   - Done at t0+165; Busy low afterwards.
2. LSB_FIRST=1, Data=16'h0001 → the first sampled bit is 1 and the remaining 15 are 0.
3. Back-to-back: frames 16'h1234 at t0, 16'hFFFF and then 16'h00FF while Busy:
   - Pend=1.
   - Second frame shifted is 16'h00FF, starting at t0+165 with no IDLE gap.
   - Two Done pulses total.
4. Rst_n asserted at bit 7 of a frame:
   - All outputs 0 immediately; no ST_CP pulse.
   - After release, a new frame 16'h8001 is sent correctly.
5. DATA_WIDTH=24, DIV_MAX=1 → 24 SH_CP pulses of period 4 cycles; Done at t0+98.
6. With HC595_AUTO_REFRESH_EN, after sending 16'hBEEF and idling 320 cycles:
   - The same waveform repeats with no Done pulse.
   - With the macro undefined, no activity follows.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 chain driver.
package hc595_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShLo,
    StShHi,
    StLatch
  } hc595_state_e;

  localparam int unsigned RefreshGapMult = 64;

  // Bit-counter width for a frame of w bits; a 1-bit counter is the floor.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/hc595_clk_div.sv
// Bit-rate divider: counts 0..DivMax while enabled and flags the terminal count.
module hc595_clk_div #(
  parameter int unsigned DivMax = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned DivW = (DivMax < 1) ? 1 : $clog2(DivMax + 1);

  logic [DivW-1:0] div_q, div_d;

  assign tick_o = (div_q == DivW'(DivMax));

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = tick_o ? '0 : div_q + DivW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial driver for daisy-chained 74HC595 shift registers with a one-frame send buffer.
// Define HC595_AUTO_REFRESH_EN to re-send the last frame after a long idle gap.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_MAX    = 4,
  parameter int unsigned LSB_FIRST  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  S_EN,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pend,
  output logic                  SH_CP,
  output logic                  ST_CP,
  output logic                  DS
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);

  hc595_state_e state_q, state_d;
  logic [CntW-1:0] bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, pend_data_q, pend_data_d;
  logic pend_q, pend_d, busy_q, busy_d, done_q, done_d;
  logic sh_cp_q, sh_cp_d, st_cp_q, st_cp_d, ds_q, ds_d;

  logic tick, start, refresh_start, refresh_due, in_refresh;
  logic [DATA_WIDTH-1:0] start_data, refresh_data;

  function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  hc595_clk_div #(
    .DivMax(DIV_MAX)
  ) u_clk_div (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .en_i  (state_q != StIdle),
    .clr_i (start),
    .tick_o(tick)
  );

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    pend_d        = pend_q;
    pend_data_d   = pend_data_q;
    sh_cp_d       = sh_cp_q;
    st_cp_d       = st_cp_q;
    ds_d          = ds_q;
    done_d        = 1'b0;
    start         = 1'b0;
    refresh_start = 1'b0;
    start_data    = Data;

    unique case (state_q)
      StIdle: begin
        if (S_EN) begin
          start = 1'b1;
        end else if (refresh_due) begin
          start         = 1'b1;
          refresh_start = 1'b1;
          start_data    = refresh_data;
        end
      end
      StShLo: begin
        if (tick) begin
          state_d = StShHi;
          sh_cp_d = 1'b1;
        end
      end
      StShHi: begin
        if (tick) begin
          sh_cp_d = 1'b0;
          if (bitcnt_q == CntW'(DATA_WIDTH - 1)) begin
            state_d = StLatch;
            st_cp_d = 1'b1;
          end else begin
            state_d  = StShLo;
            bitcnt_d = bitcnt_q + CntW'(1);
            shreg_d  = shift_once(shreg_q);
            ds_d     = lead_bit(shift_once(shreg_q));
          end
        end
      end
      StLatch: begin
        if (tick) begin
          st_cp_d = 1'b0;
          done_d  = !in_refresh;
          if (S_EN) begin
            start = 1'b1;
          end else if (pend_q) begin
            start      = 1'b1;
            start_data = pend_data_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d  = StShLo;
      bitcnt_d = '0;
      shreg_d  = start_data;
      ds_d     = lead_bit(start_data);
      sh_cp_d  = 1'b0;
      st_cp_d  = 1'b0;
      pend_d   = 1'b0;
    end else if (S_EN && state_q != StIdle) begin
      // Latest request wins; the in-flight shift register is never touched.
      pend_d      = 1'b1;
      pend_data_d = Data;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sh_cp_q     <= 1'b0;
      st_cp_q     <= 1'b0;
      ds_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sh_cp_q     <= sh_cp_d;
      st_cp_q     <= st_cp_d;
      ds_q        <= ds_d;
    end
  end

`ifdef HC595_AUTO_REFRESH_EN
  localparam int unsigned RefreshGap = RefreshGapMult * (DIV_MAX + 1);
  localparam int unsigned GapW       = $clog2(RefreshGap);

  logic [GapW-1:0] gap_q, gap_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic last_vld_q, last_vld_d, in_refresh_q, in_refresh_d;

  always_comb begin
    gap_d        = '0;
    last_d       = last_q;
    last_vld_d   = last_vld_q;
    in_refresh_d = in_refresh_q;
    if (state_q == StIdle && state_d == StIdle && last_vld_q) begin
      gap_d = gap_q + GapW'(1);
    end
    if (start) begin
      in_refresh_d = refresh_start;
      if (!refresh_start) begin
        last_d     = start_data;
        last_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      gap_q        <= '0;
      last_q       <= '0;
      last_vld_q   <= 1'b0;
      in_refresh_q <= 1'b0;
    end else begin
      gap_q        <= gap_d;
      last_q       <= last_d;
      last_vld_q   <= last_vld_d;
      in_refresh_q <= in_refresh_d;
    end
  end

  assign refresh_due  = (state_q == StIdle) && last_vld_q && (gap_q == GapW'(RefreshGap - 1));
  assign refresh_data = last_q;
  assign in_refresh   = in_refresh_q;
`else
  assign refresh_due  = 1'b0;
  assign refresh_data = '0;
  assign in_refresh   = 1'b0;
`endif

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Pend  = pend_q;
  assign SH_CP = sh_cp_q;
  assign ST_CP = st_cp_q;
  assign DS    = ds_q;

endmodule
